// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - shared types and constants for the stage sequencer
package stage_seq_pkg;

    localparam int NUM_STAGES = 8;
    localparam int CNT_W      = 16;
    localparam int SW         = $clog2(NUM_STAGES + 1);
    localparam int IDX_W      = $clog2(NUM_STAGES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef logic [SW-1:0]    stage_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam stage_t FINISHED_STAGE = stage_t'(NUM_STAGES);

endpackage

// File: rtl/stage_next_find.sv
// rtl/stage_next_find.sv - lowest nonzero-length stage at or above a start index
module stage_next_find
    import stage_seq_pkg::*;
(
    input  logic [NUM_STAGES-1:0] nz_i,
    input  stage_t                from_i,
    output stage_t                idx_o,
    output logic                  none_o
);

    // Descending scan so the lowest qualifying stage is the one left standing.
    always_comb begin
        idx_o  = FINISHED_STAGE;
        none_o = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (nz_i[i] && (stage_t'(i) >= from_i)) begin
                idx_o  = stage_t'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - programmable stage sequencer for the fp16 reduction pipe
// Optional perf counters: define STAGE_SEQ_PERF_EN.
module stage_sequencer
    import stage_seq_pkg::*;
(
    input  logic                        clk_i,
`ifdef STAGE_SEQ_PERF_EN
    output logic [31:0]                 perf_cycles_o,
    output logic [31:0]                 perf_stalls_o,
`endif
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        ready_o,
    input  cnt_t [NUM_STAGES-1:0]       cfg_len_i,
    input  logic [NUM_STAGES-1:0]       cfg_rst_mask_i,
    input  logic [NUM_STAGES-1:0]       cfg_mode_mask_i,
    input  logic                        stall_i,
    input  logic                        abort_i,
    output stage_t                      stage_o,
    output cnt_t                        step_o,
    output logic                        valid_o,
    output logic                        first_o,
    output logic                        last_o,
    output logic                        mode_o,
    output logic                        red_rst_o,
    output logic                        busy_o,
    output logic                        done_o
);

    state_e                state_q, state_d;
    stage_t                stage_q, stage_d;
    cnt_t                  step_q, step_d;
    cnt_t [NUM_STAGES-1:0] len_q;
    logic [NUM_STAGES-1:0] rst_mask_q, mode_mask_q;
    logic [NUM_STAGES-1:0] nz_q, cfg_nz, find_vec;
    stage_t                find_from, find_idx;
    logic                  find_none;
    logic [IDX_W-1:0]      cur_idx;
    logic                  in_run, at_last, accept;

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            nz_q[i]   = (len_q[i] != '0);
            cfg_nz[i] = (cfg_len_i[i] != '0);
        end
    end

    assign in_run  = (state_q == S_RUN);
    assign accept  = (state_q == S_IDLE) && start_i && !abort_i;
    assign cur_idx = stage_q[IDX_W-1:0];
    assign at_last = (step_q == (len_q[cur_idx] - cnt_t'(1)));

    // One search serves both the start lookup (live cfg) and the advance lookup (latched cfg).
    assign find_vec  = (state_q == S_IDLE) ? cfg_nz : nz_q;
    assign find_from = (state_q == S_IDLE) ? stage_t'(0) : stage_q + stage_t'(1);

    stage_next_find u_find (
        .nz_i   (find_vec),
        .from_i (find_from),
        .idx_o  (find_idx),
        .none_o (find_none)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        step_d  = step_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    step_d = '0;
                    if (find_none) begin
                        state_d = S_DONE;
                        stage_d = FINISHED_STAGE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = find_idx;
                    end
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    stage_d = FINISHED_STAGE;
                    step_d  = '0;
                end else if (!stall_i) begin
                    if (!at_last) begin
                        step_d = step_q + cnt_t'(1);
                    end else begin
                        step_d = '0;
                        if (find_none) begin
                            state_d = S_DONE;
                            stage_d = FINISHED_STAGE;
                        end else begin
                            stage_d = find_idx;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = FINISHED_STAGE;
                step_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                stage_d = FINISHED_STAGE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            stage_q     <= FINISHED_STAGE;
            step_q      <= '0;
            len_q       <= '0;
            rst_mask_q  <= '0;
            mode_mask_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            step_q  <= step_d;
            if (accept) begin
                len_q       <= cfg_len_i;
                rst_mask_q  <= cfg_rst_mask_i;
                mode_mask_q <= cfg_mode_mask_i;
            end
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign stage_o   = stage_q;
    assign step_o    = step_q;
    assign first_o   = in_run && (step_q == '0);
    assign last_o    = in_run && at_last;
    assign mode_o    = in_run && mode_mask_q[cur_idx];
    assign valid_o   = in_run && !stall_i;
    assign red_rst_o = first_o && rst_mask_q[cur_idx] && !stall_i;

`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (in_run) begin
            if (!(&perf_cycles_q)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (stall_i && !(&perf_stalls_q)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stalls_o = perf_stalls_q;
`endif

endmodule
